// File: rtl/controlador_venda_if.sv
// Signal bundle between the vending-machine controller and its environment
// (coin acceptor, product buttons, change dispenser, coin accumulator).
interface controlador_venda_if;
  logic [1:0] moeda;
  logic       sel_valida;
  logic [1:0] selecao;
  logic       cancelar;
  logic       troco_ack;
  logic [3:0] credito;

  logic [1:0] moeda_acum;
  logic       tempoLimite;
  logic       moeda_rejeitada;
  logic       liberar;
  logic [1:0] produto;
  logic       preco_insuf;
  logic [3:0] troco;
  logic       troco_valido;
  logic       ocupado;

  modport master (
    output moeda, sel_valida, selecao, cancelar, troco_ack, credito,
    input  moeda_acum, tempoLimite, moeda_rejeitada, liberar, produto,
           preco_insuf, troco, troco_valido, ocupado
  );

  modport slave (
    input  moeda, sel_valida, selecao, cancelar, troco_ack, credito,
    output moeda_acum, tempoLimite, moeda_rejeitada, liberar, produto,
           preco_insuf, troco, troco_valido, ocupado
  );
endinterface

// File: rtl/controlador_venda.sv
// Vending transaction sequencer: gates coins into the external accumulator,
// handles selection/price check, product release, change and inactivity timeout.
module controlador_venda #(
    parameter int PRECO0         = 4,
    parameter int PRECO1         = 5,
    parameter int PRECO2         = 6,
    parameter int PRECO3         = 8,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input logic                  clk,
    input logic                  rst_n,
    controlador_venda_if.slave   bus
);

    localparam int CW = $clog2(TIMEOUT_CICLOS);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        LIMPAR,
        OCIOSO,
        ACEITANDO,
        ESPERA,
        COMPARAR,
        LIBERAR,
        TROCO
    } estado_t;

    estado_t       r_estado;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_moeda_acum;
    logic          r_tempo_limite;
    logic          r_moeda_rejeitada;
    logic          r_liberar;
    logic [1:0]    r_produto;
    logic          r_preco_insuf;
    logic [3:0]    r_troco;
    logic          r_troco_valido;
    logic          r_ocupado;

    estado_t       w_prox;
    logic [CW-1:0] w_cnt;
    logic [1:0]    w_moeda_acum;
    logic          w_aceita;
    logic          w_rejeita;
    logic          w_preco_insuf;
    logic [3:0]    w_troco;
    logic [1:0]    w_produto;
    logic [4:0]    w_reembolso;
    logic [4:0]    w_soma;
    logic          w_cabe;
    logic          w_tem_moeda;
    logic          w_timeout;
    logic [3:0]    w_preco;

    function automatic logic [2:0] peso(input logic [1:0] m);
        case (m)
            2'b01:   peso = 3'd1;
            2'b10:   peso = 3'd2;
            2'b11:   peso = 3'd4;
            default: peso = 3'd0;
        endcase
    endfunction

    // The coin still in flight to the accumulator counts towards the 2,00 ceiling.
    assign w_reembolso = {1'b0, bus.credito} + {2'b00, peso(r_moeda_acum)};
    assign w_soma      = w_reembolso + {2'b00, peso(bus.moeda)};
    assign w_cabe      = (w_soma <= 5'd8);
    assign w_tem_moeda = (bus.moeda != 2'b00);
    assign w_timeout   = (r_cnt == CNT_MAX);

    always_comb begin
        case (r_produto)
            2'd0:    w_preco = 4'(PRECO0);
            2'd1:    w_preco = 4'(PRECO1);
            2'd2:    w_preco = 4'(PRECO2);
            default: w_preco = 4'(PRECO3);
        endcase
    end

    always_comb begin
        w_prox        = r_estado;
        w_aceita      = 1'b0;
        w_rejeita     = 1'b0;
        w_preco_insuf = 1'b0;
        w_troco       = r_troco;
        w_produto     = r_produto;

        case (r_estado)
            LIMPAR: begin
                w_rejeita = w_tem_moeda;
                w_prox    = OCIOSO;
            end
            OCIOSO: begin
                if (w_tem_moeda) begin
                    if (w_cabe) begin
                        w_aceita = 1'b1;
                        w_prox   = ACEITANDO;
                    end else begin
                        w_rejeita = 1'b1;
                    end
                end
            end
            ACEITANDO: begin
                if (bus.cancelar || w_timeout) begin
                    w_rejeita = w_tem_moeda;
                    w_troco   = w_reembolso[3:0];
                    w_prox    = (w_reembolso != 5'd0) ? TROCO : LIMPAR;
                end else if (bus.sel_valida) begin
                    w_rejeita = w_tem_moeda;
                    w_produto = bus.selecao;
                    w_prox    = ESPERA;
                end else if (w_tem_moeda) begin
                    if (w_cabe) w_aceita  = 1'b1;
                    else        w_rejeita = 1'b1;
                end
            end
            ESPERA: begin
                w_rejeita = w_tem_moeda;
                w_prox    = COMPARAR;
            end
            COMPARAR: begin
                w_rejeita = w_tem_moeda;
                if (bus.credito >= w_preco) begin
                    w_troco = bus.credito - w_preco;
                    w_prox  = LIBERAR;
                end else begin
                    w_preco_insuf = 1'b1;
                    w_prox        = ACEITANDO;
                end
            end
            LIBERAR: begin
                w_rejeita = w_tem_moeda;
                w_prox    = (r_troco != 4'd0) ? TROCO : LIMPAR;
            end
            TROCO: begin
                w_rejeita = w_tem_moeda;
                if (bus.troco_ack) w_prox = LIMPAR;
            end
            default: w_prox = LIMPAR;
        endcase

        w_moeda_acum = w_aceita ? bus.moeda : 2'b00;

        // Timer restarts on every entry into ACEITANDO and on each accepted coin.
        if (w_prox == ACEITANDO && (r_estado != ACEITANDO || w_aceita))
            w_cnt = '0;
        else if (r_estado == ACEITANDO)
            w_cnt = r_cnt + 1'b1;
        else
            w_cnt = r_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado          <= LIMPAR;
            r_cnt             <= '0;
            r_moeda_acum      <= '0;
            r_tempo_limite    <= 1'b1;
            r_moeda_rejeitada <= 1'b0;
            r_liberar         <= 1'b0;
            r_produto         <= '0;
            r_preco_insuf     <= 1'b0;
            r_troco           <= '0;
            r_troco_valido    <= 1'b0;
            r_ocupado         <= 1'b1;
        end else begin
            r_estado          <= w_prox;
            r_cnt             <= w_cnt;
            r_moeda_acum      <= w_moeda_acum;
            r_tempo_limite    <= (w_prox == LIMPAR);
            r_moeda_rejeitada <= w_rejeita;
            r_liberar         <= (w_prox == LIBERAR);
            r_produto         <= w_produto;
            r_preco_insuf     <= w_preco_insuf;
            r_troco           <= w_troco;
            r_troco_valido    <= (w_prox == TROCO);
            r_ocupado         <= (w_prox != OCIOSO);
        end
    end

    assign bus.moeda_acum      = r_moeda_acum;
    assign bus.tempoLimite     = r_tempo_limite;
    assign bus.moeda_rejeitada = r_moeda_rejeitada;
    assign bus.liberar         = r_liberar;
    assign bus.produto         = r_produto;
    assign bus.preco_insuf     = r_preco_insuf;
    assign bus.troco           = r_troco;
    assign bus.troco_valido    = r_troco_valido;
    assign bus.ocupado         = r_ocupado;

endmodule

// File: tb/tb_controlador_venda.sv
// Directed bench for controlador_venda with a behavioural coin accumulator
// closing the loop on credito.
module tb_controlador_venda;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    controlador_venda_if bus();

    controlador_venda #(
        .PRECO0(4), .PRECO1(5), .PRECO2(6), .PRECO3(8), .TIMEOUT_CICLOS(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Accumulator: no reset of its own, cleared by tempoLimite.
    logic [3:0] acc = 4'd0;
    always @(posedge clk) begin
        if (bus.tempoLimite)              acc <= 4'd0;
        else if (bus.moeda_acum == 2'b01) acc <= acc + 4'd1;
        else if (bus.moeda_acum == 2'b10) acc <= acc + 4'd2;
        else if (bus.moeda_acum == 2'b11) acc <= acc + 4'd4;
    end
    assign bus.credito = acc;

    // Expected word: {moeda_acum, rej, liberar, produto, preco_insuf, troco, troco_valido, tempoLimite, ocupado}
    typedef struct {
        logic [1:0]  moeda;
        logic        sel;
        logic [1:0]  selc;
        logic        canc;
        logic        ack;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t v(input logic [1:0] m, input logic s, input logic [1:0] sc,
                               input logic c, input logic a,
                               input logic [1:0] ma, input logic rj, input logic lb,
                               input logic [1:0] pr, input logic pi, input logic [3:0] tr,
                               input logic tv, input logic tl, input logic oc);
        vec_t r;
        r.moeda = m; r.sel = s; r.selc = sc; r.canc = c; r.ack = a;
        r.exp = {ma, rj, lb, pr, pi, tr, tv, tl, oc};
        return r;
    endfunction

    function automatic logic [13:0] obs();
        return {bus.moeda_acum, bus.moeda_rejeitada, bus.liberar, bus.produto,
                bus.preco_insuf, bus.troco, bus.troco_valido, bus.tempoLimite, bus.ocupado};
    endfunction

    task automatic chk(input string nm, input logic [13:0] exp);
        logic [13:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b (ma,rej,lib,prod,pi,troco,tv,tl,oc)", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic s, input logic [1:0] sc,
                         input logic c, input logic a);
        bus.moeda = m; bus.sel_valida = s; bus.selecao = sc;
        bus.cancelar = c; bus.troco_ack = a;
    endtask

    initial begin
        // Exact price: 11,11 then product 3
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(3,0,0,0,0, 3,0,0,0,0,0,0,0,1));
        tbl.push_back(v(3,0,0,0,0, 3,0,0,0,0,0,0,0,1));
        tbl.push_back(v(0,1,3,0,0, 0,0,0,3,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,3,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,1,3,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,3,0,0,0,1,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,3,0,0,0,0,0));
        // Change: 11,10 then product 0 -> troco 2
        tbl.push_back(v(3,0,0,0,0, 3,0,0,3,0,0,0,0,1));
        tbl.push_back(v(2,0,0,0,0, 2,0,0,3,0,0,0,0,1));
        tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,1,0,0,2,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,2,1,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,2,1,0,1));
        tbl.push_back(v(0,0,0,0,1, 0,0,0,0,0,2,0,1,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,2,0,0,0));
        // Insufficient: 1 unit, product 2; then top up to 6 and buy
        tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,2,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,2,0,0,1));
        tbl.push_back(v(0,1,2,0,0, 0,0,0,2,0,2,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,2,0,2,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,2,1,2,0,0,1));
        tbl.push_back(v(3,0,0,0,0, 3,0,0,2,0,2,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 1,0,0,2,0,2,0,0,1));
        tbl.push_back(v(0,1,2,0,0, 0,0,0,2,0,2,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,2,0,2,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,1,2,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,2,0,0,0,1,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,2,0,0,0,0,0));
        // Overflow at 7, then coin colliding with selection of product 1
        tbl.push_back(v(3,0,0,0,0, 3,0,0,2,0,0,0,0,1));
        tbl.push_back(v(2,0,0,0,0, 2,0,0,2,0,0,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 1,0,0,2,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,2,0,0,0,0,1));
        tbl.push_back(v(2,0,0,0,0, 0,1,0,2,0,0,0,0,1));
        tbl.push_back(v(3,1,1,0,0, 0,1,0,1,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,1,1,0,2,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,0,2,1,0,1));
        tbl.push_back(v(0,0,0,0,1, 0,0,0,1,0,2,0,1,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,0,2,0,0,0));
        // Back-to-back 11,11,11: third rejected via pending term; cancel refunds 8
        tbl.push_back(v(3,0,0,0,0, 3,0,0,1,0,2,0,0,1));
        tbl.push_back(v(3,0,0,0,0, 3,0,0,1,0,2,0,0,1));
        tbl.push_back(v(3,0,0,0,0, 0,1,0,1,0,2,0,0,1));
        tbl.push_back(v(0,0,0,1,0, 0,0,0,1,0,8,1,0,1));
        tbl.push_back(v(0,0,0,0,1, 0,0,0,1,0,8,0,1,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,0,8,0,0,0));
        // Cancel while the only coin is still pending
        tbl.push_back(v(2,0,0,0,0, 2,0,0,1,0,8,0,0,1));
        tbl.push_back(v(0,0,0,1,0, 0,0,0,1,0,2,1,0,1));
        tbl.push_back(v(0,0,0,0,1, 0,0,0,1,0,2,0,1,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,0,2,0,0,0));
        // Selection and cancel ignored in OCIOSO
        tbl.push_back(v(0,1,3,1,0, 0,0,0,1,0,2,0,0,0));
        // Timeout: 3 units, 8 idle cycles -> refund 3
        tbl.push_back(v(2,0,0,0,0, 2,0,0,1,0,2,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 1,0,0,1,0,2,0,0,1));
        for (int k = 0; k < 7; k++)
            tbl.push_back(v(0,0,0,0,0, 0,0,0,1,0,2,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,0,3,1,0,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,0,3,1,0,1));

        rst_n = 1'b0;
        drive(0,0,0,0,0);
        repeat (3) @(posedge clk);
        #1 chk("reset", 14'b00_0_0_00_0_0000_0_1_1);
        rst_n = 1'b1;
        #1 chk("release", 14'b00_0_0_00_0_0000_0_1_1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].moeda, tbl[i].sel, tbl[i].selc, tbl[i].canc, tbl[i].ack);
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Asynchronous reset while in TROCO: no ack needed, restart at LIMPAR
        drive(0,0,0,0,0);
        rst_n = 1'b0;
        #1 chk("rst_in_troco", 14'b00_0_0_00_0_0000_0_1_1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rst_release2", 14'b00_0_0_00_0_0000_0_1_1);
        @(posedge clk);
        #1 chk("idle_after_rst", 14'b00_0_0_00_0_0000_0_0_0);
        drive(3,0,0,0,0);
        @(posedge clk);
        #1 chk("coin_after_rst", 14'b11_0_0_00_0_0000_0_0_1);
        drive(0,0,0,0,0);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_venda.md
# controlador_venda

Transaction sequencer for the vending machine, wrapped around the coin accumulator FSM (4-bit credit in 0.25 units, clear input `tempoLimite`). It gates coin pulses into the accumulator, rejects coins that would push credit above 2,00, and handles product selection against per-product prices. It releases the product, computes change, runs an inactivity timeout, and clears the accumulator at the end of every transaction.

## Interface
- `PRECO0`, default 4: price of product 0, in 0.25 units (1..8).
- `PRECO1`, default 5: price of product 1.
- `PRECO2`, default 6: price of product 2.
- `PRECO3`, default 8: price of product 3.
- `TIMEOUT_CICLOS`, default 1000: idle cycles in ACEITANDO before an automatic refund (≥4).
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `moeda` in 2: coin pulse, one cycle per coin. 00 none, 01 0,25, 10 0,50, 11 1,00.
- `sel_valida` in 1: one-cycle selection strobe.
- `selecao` in 2: product index, sampled with `sel_valida`.
- `cancelar` in 1: one-cycle refund request.
- `troco_ack` in 1: change dispenser accepted `troco`.
- `credito` in 4: `valorAcumulado` from the accumulator.
- `moeda_acum` out 2: registered coin pulse to the accumulator `valorMoeda`.
- `tempoLimite` out 1: accumulator clear.
- `moeda_rejeitada` out 1: one-cycle pulse; the coin is returned physically.
- `liberar` out 1: one-cycle product-release pulse.
- `produto` out 2: latched product index, valid while `liberar`=1.
- `preco_insuf` out 1: one-cycle pulse when credit is below the price.
- `troco` out 4: change in 0.25 units.
- `troco_valido` out 1: held until `troco_ack`.
- `ocupado` out 1: 1 in every state except OCIOSO.

## Operation
- Coin weights: 01→1, 10→2, 11→4 units.
- `pendente` = weight of the current `moeda_acum`.
- Accept test: `credito + pendente + weight ≤ 8`, evaluated in 5-bit arithmetic.
  - Accepted coin: `moeda_acum <= moeda` for exactly one cycle.
  - Rejected coin: `moeda_rejeitada` pulses; `moeda_acum` stays 00.
- **LIMPAR**: `tempoLimite`=1 for one cycle → OCIOSO.
- **OCIOSO**:
  - Coin accepted per the rule above → ACEITANDO.
  - `sel_valida` and `cancelar` are ignored.
- **ACEITANDO**:
  - Priority: `cancelar` > timeout > `sel_valida` > coin.
  - `cancelar` or timeout: `troco <= credito + pendente` → TROCO if nonzero, else LIMPAR.
  - `sel_valida`: latch `produto`, → ESPERA. A coin arriving in the same cycle is rejected.
  - Otherwise a coin is accepted or rejected per the rule above.
- Timeout counter:
  - Reloads to 0 on entry to ACEITANDO and on every accepted coin.
  - Expires when the count reaches `TIMEOUT_CICLOS-1`.
- **ESPERA**:
  - 1 cycle, so that `credito` includes all forwarded coins.
  - Coins are rejected.
  - → COMPARAR.
- **COMPARAR**:
  - Coins are rejected.
  - `credito ≥ PRECO[produto]`: `troco <= credito − preco` → LIBERAR.
  - Otherwise `preco_insuf` pulses → ACEITANDO, timer reloaded.
- **LIBERAR**: `liberar`=1 for one cycle, coins rejected → TROCO if `troco`≠0, else LIMPAR.
- **TROCO**:
  - `troco_valido`=1 and `troco` stable until the cycle `troco_ack`=1 is sampled → LIMPAR.
  - Coins are rejected.
- `cancelar` is ignored outside ACEITANDO.
- `moeda_rejeitada` can pulse in any state except OCIOSO/ACEITANDO-with-room.

## Timing
- Reset (`rst_n`=0), all outputs 0 except `tempoLimite`=1 and `ocupado`=1.
  - State = LIMPAR, because the accumulator itself has no reset.
  - First cycle after release: `tempoLimite`=1.
  - Next cycle: OCIOSO, `tempoLimite`=0.
- Coin at edge n → `moeda_acum` at n+1 → `credito` updated at n+2.
- Selection at edge s:
  - ESPERA at s+1, COMPARAR at s+2.
  - `liberar` at s+3; `troco_valido` at s+4 if `troco`≠0.
- `troco_ack` sampled at edge a → LIMPAR at a+1 (`tempoLimite`=1) → OCIOSO at a+2.
- Timeout: `TIMEOUT_CICLOS` cycles after the last accepted coin (or re-entry), with no coin, the next state is TROCO or LIMPAR.
- Asynchronous reset mid-transaction: credit is discarded, no `liberar` or `troco`, sequence restarts at LIMPAR.
- All outputs are registered.

## Test plan
- **Reset, release, idle:**
  - `tempoLimite` is 1 during reset and for 1 cycle after release, then 0.
  - `ocupado`=0 in OCIOSO.
- **Exact price:** coins 11, 11 (8 units), select 3.
  - `liberar`=1 with `produto`=3 at s+3.
  - `troco_valido` never asserts.
  - `tempoLimite` pulse at s+4.
- **Change:** coins 11, 10 (6 units), select 0 (price 4).
  - `liberar` pulses, then `troco`=2 with `troco_valido` held until `troco_ack`.
  - Clear follows one cycle after the ack.
- **Insufficient credit:** 1 unit, select 2.
  - `preco_insuf` pulses, no `liberar`, state back to ACEITANDO.
  - Add 11, 01, select 2 → release with `troco`=0.
- **Overflow and collision:**
  - At credit 7, coin 10 → `moeda_rejeitada`, credit stays 7.
  - Coin 11 in the same cycle as `sel_valida` → coin rejected.
  - Back-to-back coins 11, 11, 11 → third rejected via the `pendente` term.
- **Timeout and cancel:**
  - 3 units then no activity for `TIMEOUT_CICLOS` → `troco`=3 refund.
  - Separately, `cancelar` with 0 accumulated units (just after the first coin is still pending) → refund includes the pending coin.
  - `rst_n` pulse during TROCO → LIMPAR, no ack needed.
